// File: rtl/lfsr_rnd_bank.sv
// Free-running Fibonacci LFSR feeding a bank of CHANNELS random words.
// The bank fills one slot every WIDTH shifts and publishes atomically on a strobe.
module lfsr_rnd_bank #(
  parameter int              WIDTH    = 13,
  parameter int              CHANNELS = 10,
  parameter logic [WIDTH-1:0] TAPS    = 13'h100D,
  parameter logic [WIDTH-1:0] SEED    = 13'h000F
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      half_sec_pulse,
  input  logic                      seed_valid,
  input  logic [WIDTH-1:0]          seed_data,
  output logic [CHANNELS*WIDTH-1:0] rnd_flat,
  output logic                      rnd_valid,
  output logic                      bank_ready,
  output logic                      missed_pulse
);

  localparam int SW = $clog2(WIDTH);
  localparam int FW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH - 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(CHANNELS - 1);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [WIDTH-1:0]          r_lfsr;
  logic [SW-1:0]             r_step;
  logic [FW-1:0]             r_fill;
  logic [0:0]                r_state;
  logic [WIDTH-1:0]          r_slot [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] r_flat;
  logic                      r_valid;
  logic                      r_missed;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;
  logic             w_publish;
  logic             w_capture;
  logic             w_step_wrap;

  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_next      = {r_lfsr[WIDTH-2:0], w_fb};
  assign w_seed      = (seed_data == '0) ? SEED : seed_data;
  assign w_publish   = half_sec_pulse && (r_state == S_READY);
  assign w_step_wrap = (r_step == STEP_LAST);
  assign w_capture   = enable && (r_state == S_FILL) && w_step_wrap;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr   <= SEED;
      r_step   <= '0;
      r_fill   <= '0;
      r_state  <= S_FILL;
      r_flat   <= '0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (seed_valid) begin
        r_lfsr   <= w_seed;
        r_step   <= '0;
        r_fill   <= '0;
        r_state  <= S_FILL;
        r_missed <= 1'b0;
      end else begin
        if (enable)
          r_lfsr <= w_next;
        if (w_publish) begin
          for (int i = 0; i < CHANNELS; i++)
            r_flat[i*WIDTH +: WIDTH] <= r_slot[i];
          r_valid <= 1'b1;
          r_state <= S_FILL;
          r_fill  <= '0;
          r_step  <= '0;
        end else begin
          if (half_sec_pulse)
            r_missed <= 1'b1;
          if (enable) begin
            r_step <= w_step_wrap ? '0 : r_step + 1'b1;
            if (w_capture) begin
              // last slot captured: the bank is complete
              if (r_fill == FILL_LAST) begin
                r_fill  <= '0;
                r_state <= S_READY;
              end else begin
                r_fill <= r_fill + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // slot contents need no reset; they are only published once fully written
  always_ff @(posedge clock) begin
    if (!reset && !seed_valid && !w_publish && w_capture)
      r_slot[r_fill] <= w_next;
  end

  assign rnd_flat     = r_flat;
  assign rnd_valid    = r_valid;
  assign bank_ready   = (r_state == S_READY);
  assign missed_pulse = r_missed;

endmodule
